// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder: funct3 codes,
// FSM state encoding and the captured request payload.
package mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned F3_W_BITS = 3;
  localparam int unsigned CNT_W = 4;

  localparam logic [F3_W_BITS-1:0] F3_B  = 3'b000;
  localparam logic [F3_W_BITS-1:0] F3_H  = 3'b001;
  localparam logic [F3_W_BITS-1:0] F3_W  = 3'b010;
  localparam logic [F3_W_BITS-1:0] F3_BU = 3'b100;
  localparam logic [F3_W_BITS-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                 we;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    wdata;
    logic [F3_W_BITS-1:0] funct3;
  } mem_req_t;

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane steering for stores, load extraction/extension, and the
// alignment / funct3 legality check for one request.
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic                 i_we,
  input  logic [1:0]           i_addr_lo,
  input  logic [F3_W_BITS-1:0] i_funct3,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [DATA_W-1:0]    i_rword,
  output logic [3:0]           o_be_c,
  output logic [DATA_W-1:0]    o_wdata_c,
  output logic [DATA_W-1:0]    o_rdata_c,
  output logic                 o_fmt_err_c
);

  logic [DATA_W-1:0] w_shift;

  // Addressed byte/half moved down to bit 0 before extension.
  assign w_shift = i_rword >> {i_addr_lo, 3'b000};

  always_comb begin
    o_be_c      = 4'b0000;
    o_wdata_c   = i_wdata;
    o_rdata_c   = w_shift;
    o_fmt_err_c = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_be_c    = 4'b0001 << i_addr_lo;
        o_wdata_c = {4{i_wdata[7:0]}};
        o_rdata_c = {{24{w_shift[7]}}, w_shift[7:0]};
      end
      F3_H: begin
        o_be_c      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_c   = {2{i_wdata[15:0]}};
        o_rdata_c   = {{16{w_shift[15]}}, w_shift[15:0]};
        o_fmt_err_c = i_addr_lo[0];
      end
      F3_W: begin
        o_be_c      = 4'b1111;
        o_fmt_err_c = |i_addr_lo;
      end
      F3_BU: begin
        o_rdata_c   = {24'h000000, w_shift[7:0]};
        o_fmt_err_c = i_we;
      end
      F3_HU: begin
        o_rdata_c   = {16'h0000, w_shift[15:0]};
        o_fmt_err_c = i_we | i_addr_lo[0];
      end
      default: begin
        o_fmt_err_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the core data-memory port: valid/ready request and
// response channels in front of a word RAM with configurable wait states.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [F3_W_BITS-1:0] req_funct3,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  mem_req_t          r_req, w_req_nxt;
  logic              r_err_pend, w_err_pend_nxt;
  logic              r_req_ready, w_req_ready_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;

  mem_req_t          w_in_req;
  mem_req_t          w_cur_req;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rword;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata_rep;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_fmt_err;
  logic              w_range_err;
  logic              w_illegal;
  logic              w_mem_we;

  assign w_in_req = '{we: req_we, addr: req_addr, wdata: req_wdata, funct3: req_funct3};

  // In IDLE the lane unit judges the incoming request; afterwards it works on the captured one.
  assign w_cur_req   = (r_state == S_IDLE) ? w_in_req : r_req;
  assign w_idx       = w_cur_req.addr[IDX_W+1:2];
  assign w_rword     = r_mem[w_idx];
  assign w_range_err = (w_cur_req.addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS));
  assign w_illegal   = w_range_err | w_fmt_err;

  mem_lane_unit u_lane (
    .i_we        (w_cur_req.we),
    .i_addr_lo   (w_cur_req.addr[1:0]),
    .i_funct3    (w_cur_req.funct3),
    .i_wdata     (w_cur_req.wdata),
    .i_rword     (w_rword),
    .o_be_c      (w_be),
    .o_wdata_c   (w_wdata_rep),
    .o_rdata_c   (w_ld_data),
    .o_fmt_err_c (w_fmt_err)
  );

  // State and output registers; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_req       <= '0;
      r_err_pend  <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req       <= w_req_nxt;
      r_err_pend  <= w_err_pend_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  // Next-state and output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_req_nxt       = r_req;
    w_err_pend_nxt  = r_err_pend;
    w_req_ready_nxt = r_req_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_mem_we        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && r_req_ready) begin
          // Illegal requests pass through WAIT with a zero count and skip the
          // RAM, so their response arrives one cycle after acceptance.
          w_req_nxt       = w_in_req;
          w_req_ready_nxt = 1'b0;
          w_state_nxt     = S_WAIT;
          w_err_pend_nxt  = w_illegal;
          w_cnt_nxt       = w_illegal ? '0 : CNT_W'(WAIT_STATES);
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = r_err_pend;
          w_mem_we        = r_req.we & ~r_err_pend;
          w_rsp_rdata_nxt = (r_req.we | r_err_pend) ? '0 : w_ld_data;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_rsp_rdata_nxt = '0;
          w_rsp_err_nxt   = 1'b0;
          w_req_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_req_ready_nxt = 1'b1;
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // Byte-enabled RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
